ai_addr_channel_arbiter: RTL and testbench
==========================================

# ai_addr_channel_arbiter

- Per-slave address-channel arbiter: weighted round-robin (WRR) selection of one AW or AR request from `MST_AMT` masters.
- Extends the winner's transaction ID with the master index.
- Holds the selected request in a one-entry output register.
- Caps in-flight transactions per slave at `OUTSTANDING_AMT`; one instance per slave per address channel inside the slave arbitration stage of the interconnect.

## Interface
- `MST_AMT`, 3 — number of masters.
- `OUTSTANDING_AMT`, 8 — max accepted, uncompleted transactions.
- `MST_WEIGHT`, {32'd5, 32'd3, 32'd2} — `[0:MST_AMT*32-1]`; entry i = consecutive grants allowed to master i; 0 treated as 1.
- `MST_ID_W`, $clog2(MST_AMT) — master index width.
- `ADDR_WIDTH`, 32; `TRANS_MST_ID_W`, 5; `TRANS_DATA_LEN_W`, 3; `TRANS_DATA_SIZE_W`, 3.
- `TRANS_SLV_ID_W`, TRANS_MST_ID_W+MST_ID_W — downstream ID width.

Ports:
- `ACLK_i` in 1 — clock; single clock domain.
- `ARESETn_i` in 1 — asynchronous, active-low reset.
- `m_AxID_i` in `[0:TRANS_MST_ID_W*MST_AMT-1]` — per-master ID.
- `m_AxADDR_i` in `[0:ADDR_WIDTH*MST_AMT-1]` — per-master address.
- `m_AxLEN_i` in `[0:TRANS_DATA_LEN_W*MST_AMT-1]` — per-master burst length.
- `m_AxSIZE_i` in `[0:TRANS_DATA_SIZE_W*MST_AMT-1]` — per-master beat size.
- `m_AxVALID_i` in `[0:MST_AMT-1]` — request valid, already decoded to this slave.
- `m_AxREADY_o` out `[0:MST_AMT-1]` — accept strobe, at most one bit high.
- `s_AxID_o` out `TRANS_SLV_ID_W` — {master index, master ID}.
- `s_AxADDR_o`, `s_AxLEN_o`, `s_AxSIZE_o` out — registered payload.
- `s_AxVALID_o` out 1 — output register valid.
- `s_AxREADY_i` in 1 — slave ready.
- `s_done_i` in 1 — one-cycle pulse per completed transaction (B handshake or RLAST handshake).
- `grant_vld_o` out 1 — pulse on each accept; steers W data.
- `grant_mst_o` out `MST_ID_W` — accepted master index, valid with `grant_vld_o`.
- `out_cnt_o` out $clog2(OUTSTANDING_AMT+1) — in-flight count.

## Operation
Load condition:
- `load = (~s_AxVALID_o | s_AxREADY_i) & (out_cnt < OUTSTANDING_AMT) & |m_AxVALID_i`.

Winner selection:
- Winner `w` = first requesting master searching from `ptr` upward, wrapping mod `MST_AMT`.
- On load, `m_AxREADY_o[w]`=1 (combinational), `grant_vld_o`=1, `grant_mst_o`=w.

WRR state is `ptr` plus `burst_cnt`. On each grant:
- `c = (w==ptr ? burst_cnt : 0) + 1`.
- If `c >= W[w]`: `ptr <= (w+1) mod MST_AMT`, `burst_cnt <= 0`.
- Else: `ptr <= w`, `burst_cnt <= c`.
- A master that drops VALID forfeits its remaining burst.

Output register:
- Loads payload on `load`.
- `s_AxID_o = {w, m_AxID[w]}` — master index in the MSBs.
- `s_AxVALID_o` clears on `s_AxREADY_i` without a new load.
- Payload holds stable while `s_AxVALID_o & ~s_AxREADY_i`.

Outstanding counter:
- +1 on grant, −1 on `s_done_i`; both in one cycle → unchanged.
- `s_done_i` at 0 is ignored (no underflow).
- At `OUTSTANDING_AMT` no grants occur; a `s_done_i` in that cycle re-enables grants in the next cycle.

Reset, applied at any time:
- `ptr`=0, `burst_cnt`=0, `out_cnt`=0.
- All outputs 0; `m_AxREADY_o`=0 while `ARESETn_i` is low.
- In-flight state is discarded.

## Timing
- Request accepted in cycle N → `s_AxVALID_o`=1 in N+1.
- Back-to-back throughput: 1 per cycle when `s_AxREADY_i` is held high.
- No combinational path from `m_AxVALID_i` to any `s_*` output; `s_AxREADY_i` → `m_AxREADY_o` is combinational, one level through the load condition.
- Master-side handshake: the master must hold VALID and payload until its READY bit is seen.

## Configuration
- `AI_WRR_EN` defined: weights from `MST_WEIGHT` are used as above.
- `AI_WRR_EN` undefined: all weights are forced to 1 (plain round-robin, `ptr` always advances to w+1), `burst_cnt` is not instantiated, and `MST_WEIGHT` is ignored.

## Structure
- Shared package `ai_pkg`: payload width constants (`TRANS_*` defaults), the default weight vector, and the outstanding-counter width function.
- One sub-module, `ai_wrr_arbiter`: request vector in, winner index plus one-hot grant out, owns `ptr`/`burst_cnt`, advances only on an external `grant_en`.
- Top level owns the output register, ID concatenation and outstanding counter.

## Test plan
- All three masters hold VALID, `s_AxREADY_i`=1, `s_done_i` pulsed each cycle → grant sequence 0,0,0,0,0,1,1,1,2,2 then repeats.
- Same stimulus without `AI_WRR_EN` → sequence 0,1,2,0,1,2.
- Only master 2 requests, ID 5'h1A, addr 0x4000_0010 → N+1: `s_AxID_o`=7'b10_11010, `s_AxADDR_o`=0x4000_0010, `grant_mst_o`=2.
- `s_AxREADY_i`=0 for 4 cycles with master 1 requesting → payload stable, `m_AxREADY_o`=0 after the first load, `out_cnt_o`=1.
- No `s_done_i`, 9 requests → exactly 8 accepted, `out_cnt_o`=8; a `s_done_i` pulse → 9th accepted the next cycle.
- Reset asserted mid-stall with `out_cnt_o`=3 → all outputs 0 immediately; after release, master 0 wins first.

Source files
------------

// File: rtl/ai_pkg.sv
// Shared constants for the AI interconnect address-channel arbiter: payload widths,
// default master weights and the outstanding-counter width helper.
package ai_pkg;

    localparam int TRANS_MST_ID_W_DEF    = 5;
    localparam int TRANS_DATA_LEN_W_DEF  = 3;
    localparam int TRANS_DATA_SIZE_W_DEF = 3;

    localparam logic [0:3*32-1] MST_WEIGHT_DEF = {32'd5, 32'd3, 32'd2};

    function automatic int out_cnt_w(input int outstanding);
        return $clog2(outstanding + 1);
    endfunction

endpackage

// File: rtl/ai_wrr_arbiter.sv
// Weighted round-robin winner select; state advances only when grant_en is high.
// Weighting is compiled in with AI_WRR_EN, otherwise plain round-robin.
module ai_wrr_arbiter
    import ai_pkg::*;
#(
    parameter int                    MST_AMT    = 3,
    parameter logic [0:MST_AMT*32-1] MST_WEIGHT = MST_WEIGHT_DEF,
    parameter int                    MST_ID_W   = $clog2(MST_AMT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [0:MST_AMT-1]  req,
    input  logic                grant_en,
    output logic [MST_ID_W-1:0] winner,
    output logic [0:MST_AMT-1]  grant_onehot
);

    logic [MST_ID_W-1:0] ptr;
    logic                found;

    function automatic logic [MST_ID_W-1:0] wrap_inc(input logic [MST_ID_W-1:0] idx);
        return (int'(idx) == MST_AMT - 1) ? '0 : idx + MST_ID_W'(1);
    endfunction

    // First requester at or after ptr, wrapping around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < MST_AMT; k++) begin
            if (!found && req[(int'(ptr) + k) % MST_AMT]) begin
                found  = 1'b1;
                winner = MST_ID_W'((int'(ptr) + k) % MST_AMT);
            end
        end
    end

    always_comb begin
        grant_onehot         = '0;
        grant_onehot[winner] = found;
    end

`ifdef AI_WRR_EN
    logic [31:0] burst_cnt;
    logic [31:0] next_cnt;
    logic [31:0] cur_weight;

    // A zero weight still allows one grant; a switch away from ptr restarts the burst.
    always_comb begin
        cur_weight = MST_WEIGHT[int'(winner)*32 +: 32];
        if (cur_weight == 32'd0) cur_weight = 32'd1;
        next_cnt = ((winner == ptr) ? burst_cnt : 32'd0) + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            burst_cnt <= '0;
        end else if (grant_en) begin
            if (next_cnt >= cur_weight) begin
                ptr       <= wrap_inc(winner);
                burst_cnt <= '0;
            end else begin
                ptr       <= winner;
                burst_cnt <= next_cnt;
            end
        end
    end
`else
    logic unused_weight;
    assign unused_weight = ^MST_WEIGHT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_en) begin
            ptr <= wrap_inc(winner);
        end
    end
`endif

endmodule

// File: rtl/ai_addr_channel_arbiter.sv
// Per-slave AW/AR arbiter: WRR winner select, ID extension, one-entry output register and
// outstanding-transaction cap. Optional weighting via the AI_WRR_EN macro.
module ai_addr_channel_arbiter
    import ai_pkg::*;
#(
    parameter int                    MST_AMT           = 3,
    parameter int                    OUTSTANDING_AMT   = 8,
    parameter logic [0:MST_AMT*32-1] MST_WEIGHT        = MST_WEIGHT_DEF,
    parameter int                    MST_ID_W          = $clog2(MST_AMT),
    parameter int                    ADDR_WIDTH        = 32,
    parameter int                    TRANS_MST_ID_W    = TRANS_MST_ID_W_DEF,
    parameter int                    TRANS_DATA_LEN_W  = TRANS_DATA_LEN_W_DEF,
    parameter int                    TRANS_DATA_SIZE_W = TRANS_DATA_SIZE_W_DEF,
    parameter int                    TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W
) (
    input  logic                                     ACLK_i,
    input  logic                                     ARESETn_i,
    input  logic [0:TRANS_MST_ID_W*MST_AMT-1]        m_AxID_i,
    input  logic [0:ADDR_WIDTH*MST_AMT-1]            m_AxADDR_i,
    input  logic [0:TRANS_DATA_LEN_W*MST_AMT-1]      m_AxLEN_i,
    input  logic [0:TRANS_DATA_SIZE_W*MST_AMT-1]     m_AxSIZE_i,
    input  logic [0:MST_AMT-1]                       m_AxVALID_i,
    output logic [0:MST_AMT-1]                       m_AxREADY_o,
    output logic [TRANS_SLV_ID_W-1:0]                s_AxID_o,
    output logic [ADDR_WIDTH-1:0]                    s_AxADDR_o,
    output logic [TRANS_DATA_LEN_W-1:0]              s_AxLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0]             s_AxSIZE_o,
    output logic                                     s_AxVALID_o,
    input  logic                                     s_AxREADY_i,
    input  logic                                     s_done_i,
    output logic                                     grant_vld_o,
    output logic [MST_ID_W-1:0]                      grant_mst_o,
    output logic [out_cnt_w(OUTSTANDING_AMT)-1:0]    out_cnt_o
);

    localparam int CNT_W = out_cnt_w(OUTSTANDING_AMT);

    logic                         load;
    logic                         slot_free;
    logic                         room;
    logic                         done_eff;
    logic [MST_ID_W-1:0]          winner;
    logic [0:MST_AMT-1]           grant_onehot;
    logic [TRANS_MST_ID_W-1:0]    sel_id;
    logic [ADDR_WIDTH-1:0]        sel_addr;
    logic [TRANS_DATA_LEN_W-1:0]  sel_len;
    logic [TRANS_DATA_SIZE_W-1:0] sel_size;

    ai_wrr_arbiter #(
        .MST_AMT    (MST_AMT),
        .MST_WEIGHT (MST_WEIGHT),
        .MST_ID_W   (MST_ID_W)
    ) u_wrr (
        .clk          (ACLK_i),
        .rst_n        (ARESETn_i),
        .req          (m_AxVALID_i),
        .grant_en     (load),
        .winner       (winner),
        .grant_onehot (grant_onehot)
    );

    // Reset is folded in so READY and the grant strobe stay low while reset is held.
    assign slot_free = ~s_AxVALID_o | s_AxREADY_i;
    assign room      = out_cnt_o < CNT_W'(OUTSTANDING_AMT);
    assign load      = ARESETn_i & slot_free & room & (|m_AxVALID_i);
    assign done_eff  = s_done_i & (out_cnt_o != '0);

    assign m_AxREADY_o = load ? grant_onehot : '0;
    assign grant_vld_o = load;
    assign grant_mst_o = load ? winner : '0;

    always_comb begin
        sel_id   = m_AxID_i[int'(winner)*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        sel_addr = m_AxADDR_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = m_AxLEN_i[int'(winner)*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
        sel_size = m_AxSIZE_i[int'(winner)*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            s_AxVALID_o <= 1'b0;
            s_AxID_o    <= '0;
            s_AxADDR_o  <= '0;
            s_AxLEN_o   <= '0;
            s_AxSIZE_o  <= '0;
        end else if (load) begin
            s_AxVALID_o <= 1'b1;
            s_AxID_o    <= {winner, sel_id};
            s_AxADDR_o  <= sel_addr;
            s_AxLEN_o   <= sel_len;
            s_AxSIZE_o  <= sel_size;
        end else if (s_AxREADY_i) begin
            s_AxVALID_o <= 1'b0;
        end
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            out_cnt_o <= '0;
        end else if (load && !done_eff) begin
            out_cnt_o <= out_cnt_o + CNT_W'(1);
        end else if (!load && done_eff) begin
            out_cnt_o <= out_cnt_o - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ai_addr_channel_arbiter.sv
// Randomised and directed bench for ai_addr_channel_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_ai_addr_channel_arbiter;

    localparam int N = 3, IDW = 5, AW = 32, LW = 3, SW = 3, MW = 2, SIDW = 7, OUTS = 8, CW = 4;

`ifdef AI_WRR_EN
    int wt[N] = '{5, 3, 2};
    int exp_seq[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 2};
`else
    int wt[N] = '{1, 1, 1};
    int exp_seq[10] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [0:IDW*N-1] m_id;
    logic [0:AW*N-1]  m_addr;
    logic [0:LW*N-1]  m_len;
    logic [0:SW*N-1]  m_size;
    logic [0:N-1]     m_valid;
    logic [0:N-1]     m_ready;
    logic [SIDW-1:0]  s_id;
    logic [AW-1:0]    s_addr;
    logic [LW-1:0]    s_len;
    logic [SW-1:0]    s_size;
    logic             s_valid;
    logic             s_ready = 1'b0;
    logic             s_done = 1'b0;
    logic             grant_vld;
    logic [MW-1:0]    grant_mst;
    logic [CW-1:0]    out_cnt;

    logic [IDW-1:0] r_id[N];
    logic [AW-1:0]  r_addr[N];
    logic [LW-1:0]  r_len[N];
    logic [SW-1:0]  r_size[N];
    logic           r_vld[N];

    always #5 clk = ~clk;

    always_comb begin
        m_id = '0; m_addr = '0; m_len = '0; m_size = '0; m_valid = '0;
        for (int i = 0; i < N; i++) begin
            m_id[i*IDW +: IDW]  = r_id[i];
            m_addr[i*AW +: AW]  = r_addr[i];
            m_len[i*LW +: LW]   = r_len[i];
            m_size[i*SW +: SW]  = r_size[i];
            m_valid[i]          = r_vld[i];
        end
    end

    ai_addr_channel_arbiter dut (
        .ACLK_i(clk), .ARESETn_i(rst_n),
        .m_AxID_i(m_id), .m_AxADDR_i(m_addr), .m_AxLEN_i(m_len), .m_AxSIZE_i(m_size),
        .m_AxVALID_i(m_valid), .m_AxREADY_o(m_ready),
        .s_AxID_o(s_id), .s_AxADDR_o(s_addr), .s_AxLEN_o(s_len), .s_AxSIZE_o(s_size),
        .s_AxVALID_o(s_valid), .s_AxREADY_i(s_ready), .s_done_i(s_done),
        .grant_vld_o(grant_vld), .grant_mst_o(grant_mst), .out_cnt_o(out_cnt)
    );

    int n_vec = 0, n_err = 0;

    // Model: current favoured master, grants left in its burst, and the slave-side register.
    int cur, left, e_cnt, acc;
    bit fresh, e_sv;
    logic [SIDW-1:0] e_id;
    logic [AW-1:0]   e_addr;
    logic [LW-1:0]   e_len;
    logic [SW-1:0]   e_size;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cur = 0; left = 0; fresh = 1; e_sv = 0; e_cnt = 0; acc = -1;
        e_id = '0; e_addr = '0; e_len = '0; e_size = '0;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            r_vld[i] = 0; r_id[i] = '0; r_addr[i] = '0; r_len[i] = '0; r_size[i] = '0;
        end
    endtask

    task automatic new_req(input int i);
        r_vld[i]  = 1;
        r_id[i]   = IDW'($urandom);
        r_addr[i] = $urandom;
        r_len[i]  = LW'($urandom);
        r_size[i] = SW'($urandom);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ready", m_ready, 0);
        chk("rst_svalid", s_valid, 0);
        chk("rst_sid", s_id, 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_gvld", grant_vld, 0);
        chk("rst_gmst", grant_mst, 0);
        chk("rst_cnt", out_cnt, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: check at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        bit any, ld;
        int w;
        logic [0:N-1] er;
        @(negedge clk);
        any = 0; w = 0;
        for (int i = 0; i < N; i++) any |= r_vld[i];
        for (int k = N - 1; k >= 0; k--) if (r_vld[(cur + k) % N]) w = (cur + k) % N;
        ld = (!e_sv || s_ready) && (e_cnt < OUTS) && any;
        er = '0;
        if (ld) er[w] = 1'b1;
        chk("m_ready", m_ready, er);
        chk("grant_vld", grant_vld, ld);
        chk("grant_mst", grant_mst, ld ? w : 0);
        chk("s_valid", s_valid, e_sv);
        chk("s_id", s_id, e_id);
        chk("s_addr", s_addr, e_addr);
        chk("s_len", s_len, e_len);
        chk("s_size", s_size, e_size);
        chk("out_cnt", out_cnt, e_cnt);
        acc = ld ? w : -1;
        if (ld) begin
            if (fresh || w != cur) left = wt[w];
            left--;
            if (left == 0) begin cur = (w + 1) % N; fresh = 1; end
            else begin cur = w; fresh = 0; end
            e_sv = 1; e_id = {MW'(w), r_id[w]};
            e_addr = r_addr[w]; e_len = r_len[w]; e_size = r_size[w];
        end else if (s_ready) begin
            e_sv = 0;
        end
        e_cnt = e_cnt + (ld ? 1 : 0) - ((s_done && e_cnt > 0) ? 1 : 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int seq[$];
        int n_acc;
        clear_reqs();
        model_reset();
        apply_reset();

        // WRR sequence, all masters saturating, completions every cycle
        for (int i = 0; i < N; i++) new_req(i);
        s_ready = 1; s_done = 1;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (acc >= 0) begin seq.push_back(acc); new_req(acc); end
        end
        for (int i = 0; i < 10; i++) chk($sformatf("seq%0d", i), seq[i], exp_seq[i]);

        // Lone master 2: ID extension and payload at N+1
        s_done = 0; clear_reqs(); apply_reset();
        r_vld[2] = 1; r_id[2] = 5'h1A; r_addr[2] = 32'h4000_0010; r_len[2] = 3'd4; r_size[2] = 3'd2;
        cycle();
        chk("m2_grant", acc, 2);
        r_vld[2] = 0;
        chk("m2_sid", s_id, 7'b10_11010);
        chk("m2_saddr", s_addr, 32'h4000_0010);
        chk("m2_svalid", s_valid, 1);
        cycle();

        // Stall with master 1 requesting: payload holds, one in flight
        clear_reqs(); apply_reset();
        s_ready = 0;
        r_vld[1] = 1; r_id[1] = 5'h03; r_addr[1] = 32'h1234_5678; r_len[1] = 3'd1; r_size[1] = 3'd3;
        cycle();
        r_addr[1] = 32'hDEAD_BEEF; r_id[1] = 5'h07;
        for (int c = 0; c < 4; c++) cycle();
        chk("stall_addr", s_addr, 32'h1234_5678);
        chk("stall_cnt", out_cnt, 1);
        chk("stall_ready", m_ready, 0);

        // Outstanding cap: 9 requests, 8 accepted, a completion frees the ninth
        clear_reqs(); apply_reset();
        s_ready = 1; s_done = 0; n_acc = 0;
        for (int i = 0; i < N; i++) new_req(i);
        for (int c = 0; c < 9; c++) begin
            cycle();
            if (acc >= 0) begin n_acc++; new_req(acc); end
        end
        chk("cap_accepts", n_acc, 8);
        chk("cap_cnt", out_cnt, 8);
        s_done = 1; cycle(); s_done = 0;
        chk("cap_done_cycle", acc, -1);
        cycle();
        chk("cap_ninth", acc >= 0, 1);
        chk("cap_cnt_after", out_cnt, 8);

        // Reset in the middle of a stall with three in flight
        clear_reqs(); apply_reset();
        for (int i = 0; i < N; i++) new_req(i);
        for (int c = 0; c < 3; c++) begin cycle(); if (acc >= 0) new_req(acc); end
        s_ready = 0;
        cycle(); cycle();
        chk("mid_cnt", out_cnt, 3);
        #3;
        apply_reset();
        s_ready = 1;
        cycle();
        chk("post_rst_first", acc, 0);

        // Randomised traffic with varying completion rate
        clear_reqs(); apply_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if (!r_vld[i] && ($urandom_range(1) == 1)) new_req(i);
            s_ready = ($urandom_range(3) != 0);
            s_done  = ($urandom_range(((c / 500) % 2 == 0) ? 1 : 5) == 0);
            cycle();
            if (acc >= 0) r_vld[acc] = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
